// File: rtl/spm_pkg.sv
// spm_pkg: shared request/response types, router states and I-SPM window decode.
package spm_pkg;
  localparam int unsigned IDX_W = 12;
  localparam int unsigned TAG_W = 52;
  localparam logic [63:0] SPM_BASE_DEFAULT = 64'h0000_0000_7000_0000;
  localparam logic [63:0] SPM_SIZE_DEFAULT = 64'h0000_0000_0001_0000;
  typedef enum logic [1:0] {IDLE, SPM_WAIT, SPM_RESP} router_state_t;
  typedef struct packed {
    logic [IDX_W-1:0] address_index;
    logic [TAG_W-1:0] address_tag;
    logic [63:0]      data_wdata;
    logic             data_req;
    logic             data_we;
    logic [7:0]       data_be;
    logic [1:0]       data_size;
    logic             kill_req;
    logic             tag_valid;
  } dcache_req_i_t;
  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;
  function automatic logic spm_addr_hit(input logic [63:0] paddr, input logic [63:0] base,
                                        input logic [63:0] size);
    return (paddr & ~(size - 64'd1)) == base;
  endfunction
endpackage

// File: rtl/ispm_lsu_router.sv
// ispm_lsu_router: steers LSU requests to D-cache or I-SPM by address, keeping responses in order.
module ispm_lsu_router
  import spm_pkg::*;
#(
  parameter logic [63:0] SPM_BASE = SPM_BASE_DEFAULT,
  parameter logic [63:0] SPM_SIZE = SPM_SIZE_DEFAULT,
  parameter int unsigned MAX_DC_OUTSTANDING = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  dcache_req_i_t lsu_req_i,
  output dcache_req_o_t lsu_rsp_o,
  output dcache_req_i_t dc_req_o,
  input  dcache_req_o_t dc_rsp_i,
  output dcache_req_i_t spm_req_o,
  input  dcache_req_o_t spm_rsp_i,
  output logic          spm_hit_o
);
  localparam int unsigned CW = $clog2(MAX_DC_OUTSTANDING + 1);
  localparam logic [CW-1:0] DC_MAX = CW'(MAX_DC_OUTSTANDING);
  router_state_t state_q, state_d;
  logic [CW-1:0] dc_cnt_q, dc_cnt_d;
  logic [63:0] rdata_q, rdata_d;
  dcache_req_i_t req_q, req_d;
  logic hit, spm_fire, spm_active, spm_we, spm_wr_done, spm_rd_done;
  logic dc_go, dc_inc, dc_dec, dc_full;
  assign hit = spm_addr_hit({lsu_req_i.address_tag, lsu_req_i.address_index}, SPM_BASE, SPM_SIZE);
  assign spm_hit_o = hit & lsu_req_i.data_req;
  assign dc_full = dc_cnt_q == DC_MAX;
  // SPM is only issued once every D-cache read has returned, which keeps responses ordered
  assign spm_fire = !rst_i & state_q == IDLE & spm_hit_o & dc_cnt_q == '0;
  assign spm_active = spm_fire | (!rst_i & state_q == SPM_WAIT);
  assign spm_we = state_q == SPM_WAIT ? req_q.data_we : lsu_req_i.data_we;
  assign spm_wr_done = spm_active & spm_we & spm_rsp_i.data_gnt;
  assign spm_rd_done = spm_active & !spm_we & spm_rsp_i.data_rvalid;
  assign dc_go = !rst_i & state_q == IDLE & lsu_req_i.data_req & !hit & (lsu_req_i.data_we | !dc_full);
  assign dc_inc = dc_go & dc_rsp_i.data_gnt & !lsu_req_i.data_we;
  assign dc_dec = !rst_i & dc_rsp_i.data_rvalid & dc_cnt_q != '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = spm_rd_done ? SPM_RESP :
              spm_wr_done ? IDLE :
              spm_fire ? SPM_WAIT :
              state_q == SPM_RESP ? IDLE : state_q;
    dc_cnt_d = dc_cnt_q + CW'(dc_inc) - CW'(dc_dec);
    rdata_d = spm_rd_done ? spm_rsp_i.data_rdata : rdata_q;
    req_d = spm_fire ? lsu_req_i : req_q;
  end
  always_comb begin
    spm_req_o = state_q == SPM_WAIT ? req_q : lsu_req_i;
    spm_req_o.kill_req = 1'b0;
    spm_req_o.data_req = spm_active;
    dc_req_o = lsu_req_i;
    dc_req_o.data_req = dc_go;
    lsu_rsp_o.data_gnt = spm_wr_done | spm_rd_done | (dc_go & dc_rsp_i.data_gnt);
    lsu_rsp_o.data_rvalid = !rst_i & (state_q == SPM_RESP | dc_dec);
    lsu_rsp_o.data_rdata = !lsu_rsp_o.data_rvalid ? '0 : state_q == SPM_RESP ? rdata_q : dc_rsp_i.data_rdata;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dc_cnt_q <= '0;
      rdata_q <= '0;
      req_q <= '0;
    end else begin
      dc_cnt_q <= dc_cnt_d;
      rdata_q <= rdata_d;
      req_q <= req_d;
    end
  end
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(dc_inc & !dc_dec & dc_full));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(dc_dec & !dc_inc & dc_cnt_q == '0));
  a_rvalid_after_gnt: assert property (@(posedge clk_i) disable iff (rst_i)
    lsu_rsp_o.data_rvalid |-> (state_q == SPM_RESP || dc_cnt_q != '0));
  a_spm_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == SPM_WAIT && state_d == SPM_WAIT) |=> $stable(spm_req_o));
endmodule

// File: tb/tb_ispm_lsu_router.sv
// tb_ispm_lsu_router: directed scoreboard bench for the LSU/I-SPM router.
module tb_ispm_lsu_router;
  import spm_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic rst_v = 1'b1;
  dcache_req_i_t lsu_req_i = '0, dc_req_o, spm_req_o;
  dcache_req_o_t lsu_rsp_o, dc_rsp_i = '0, spm_rsp_i = '0;
  logic spm_hit_o;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  dcache_req_i_t r, s;

  ispm_lsu_router dut (
    .clk_i(clk_i), .rst_i(rst_i), .lsu_req_i(lsu_req_i), .lsu_rsp_o(lsu_rsp_o),
    .dc_req_o(dc_req_o), .dc_rsp_i(dc_rsp_i), .spm_req_o(spm_req_o), .spm_rsp_i(spm_rsp_i),
    .spm_hit_o(spm_hit_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic dcache_req_i_t mk(input logic [63:0] pa, input logic we, input logic [63:0] wd);
    dcache_req_i_t q;
    q = '0;
    q.address_index = pa[IDX_W-1:0];
    q.address_tag = pa[63:IDX_W];
    q.data_req = 1'b1;
    q.data_we = we;
    q.data_be = 8'hFF;
    q.data_size = 2'd3;
    q.data_wdata = wd;
    q.tag_valid = 1'b1;
    return q;
  endfunction

  // one cycle: drive after the rising edge, return at the falling edge for sampling
  task automatic cyc(input dcache_req_i_t req, input logic dg, input logic dv, input logic [63:0] dd,
                     input logic sg, input logic sv, input logic [63:0] sd);
    @(posedge clk_i);
    #1;
    rst_i = rst_v;
    lsu_req_i = req;
    dc_rsp_i.data_gnt = dg;
    dc_rsp_i.data_rvalid = dv;
    dc_rsp_i.data_rdata = dd;
    spm_rsp_i.data_gnt = sg;
    spm_rsp_i.data_rvalid = sv;
    spm_rsp_i.data_rdata = sd;
    @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    if (lsu_rsp_o.data_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected: got rvalid data %0h, required no rvalid", lsu_rsp_o.data_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (lsu_rsp_o.data_rdata !== mon_exp) begin
          errors++;
          $display("FAIL rdata_order: got %0h required %0h", lsu_rsp_o.data_rdata, mon_exp);
        end
      end
    end
  end

  initial begin
    cyc('0, 0, 0, 0, 0, 0, 0);
    check("reset_rsp", 192'(lsu_rsp_o), 0);
    cyc('0, 0, 1, 64'h77, 0, 1, 64'h66);
    check("reset_rsp_busy", 192'(lsu_rsp_o), 0);
    check("reset_dc_req", 192'(dc_req_o.data_req), 0);
    check("reset_spm_req", 192'(spm_req_o.data_req), 0);
    rst_v = 1'b0;
    cyc('0, 0, 0, 0, 0, 0, 0);
    check("idle_rsp", 192'(lsu_rsp_o), 0);

    // SPM store, granted one cycle after issue
    r = mk(64'h7000_0010, 1, 64'h1122334455667788);
    cyc(r, 0, 0, 0, 0, 0, 0);
    check("st_hit", 192'(spm_hit_o), 1);
    check("st_spm_fwd", 192'(spm_req_o), 192'(r));
    check("st_dc_req0", 192'(dc_req_o.data_req), 0);
    check("st_gnt0", 192'(lsu_rsp_o.data_gnt), 0);
    cyc(r, 0, 0, 0, 1, 0, 0);
    check("st_gnt", 192'(lsu_rsp_o.data_gnt), 1);
    check("st_dc_req1", 192'(dc_req_o.data_req), 0);
    cyc('0, 0, 0, 0, 0, 0, 0);
    check("st_idle_gnt", 192'(lsu_rsp_o.data_gnt), 0);
    check("st_idle_spm", 192'(spm_req_o.data_req), 0);

    // SPM load: gnt with SPM rvalid, LSU rvalid one cycle later
    r = mk(64'h7000_0008, 0, 0);
    cyc(r, 0, 0, 0, 0, 0, 0);
    check("ld_spm_req", 192'(spm_req_o.data_req), 1);
    cyc(mk(64'h7000_0F00, 1, 64'h5), 0, 0, 0, 0, 0, 0);
    check("ld_spm_held", 192'(spm_req_o), 192'(r));
    exp_q.push_back(64'hCA11AB1E_BADCAB1E);
    cyc(r, 0, 0, 0, 0, 1, 64'hCA11AB1E_BADCAB1E);
    check("ld_gnt", 192'(lsu_rsp_o.data_gnt), 1);
    cyc(mk(64'h0000_1000, 0, 0), 1, 0, 0, 0, 0, 0);
    check("ld_resp_no_gnt", 192'(lsu_rsp_o.data_gnt), 0);
    check("ld_resp_no_dc", 192'(dc_req_o.data_req), 0);
    cyc('0, 0, 0, 0, 0, 0, 0);
    check("ld_idle_rvalid", 192'(lsu_rsp_o.data_rvalid), 0);

    // two D-cache loads in flight hold off an SPM load
    exp_q.push_back(64'hD1D1_D1D1_0000_0001);
    cyc(mk(64'h8000_0000, 0, 0), 1, 0, 0, 0, 0, 0);
    check("dc1_req", 192'(dc_req_o.data_req), 1);
    check("dc1_gnt", 192'(lsu_rsp_o.data_gnt), 1);
    exp_q.push_back(64'hD2D2_D2D2_0000_0002);
    cyc(mk(64'h8000_0040, 0, 0), 1, 0, 0, 0, 0, 0);
    check("dc2_gnt", 192'(lsu_rsp_o.data_gnt), 1);
    s = mk(64'h7000_0020, 0, 0);
    cyc(s, 0, 0, 0, 0, 0, 0);
    check("spm_stall_hit", 192'(spm_hit_o), 1);
    check("spm_stall0", 192'(spm_req_o.data_req), 0);
    check("spm_stall_dc", 192'(dc_req_o.data_req), 0);
    cyc(s, 0, 1, 64'hD1D1_D1D1_0000_0001, 0, 0, 0);
    check("spm_stall1", 192'(spm_req_o.data_req), 0);
    cyc(s, 0, 1, 64'hD2D2_D2D2_0000_0002, 0, 0, 0);
    check("spm_stall2", 192'(spm_req_o.data_req), 0);
    exp_q.push_back(64'h5555_AAAA_3333_CCCC);
    cyc(s, 0, 0, 0, 0, 0, 0);
    check("spm_issue", 192'(spm_req_o.data_req), 1);
    cyc(s, 0, 0, 0, 0, 1, 64'h5555_AAAA_3333_CCCC);
    check("spm_ld_gnt", 192'(lsu_rsp_o.data_gnt), 1);
    cyc('0, 0, 0, 0, 0, 0, 0);
    cyc('0, 0, 0, 0, 0, 0, 0);

    // outstanding limit masks loads but not stores
    exp_q.push_back(64'hA);
    cyc(mk(64'h8000_0080, 0, 0), 1, 0, 0, 0, 0, 0);
    exp_q.push_back(64'hB);
    cyc(mk(64'h8000_00C0, 0, 0), 1, 0, 0, 0, 0, 0);
    cyc(mk(64'h8000_0100, 0, 0), 1, 0, 0, 0, 0, 0);
    check("full_ld_mask", 192'(dc_req_o.data_req), 0);
    check("full_ld_gnt0", 192'(lsu_rsp_o.data_gnt), 0);
    cyc(mk(64'h8000_0140, 1, 64'hBEEF), 1, 0, 0, 0, 0, 0);
    check("full_st_pass", 192'(dc_req_o.data_req), 1);
    check("full_st_gnt", 192'(lsu_rsp_o.data_gnt), 1);
    cyc('0, 0, 1, 64'hA, 0, 0, 0);
    // grant and return together with one read in flight keep the count at one
    exp_q.push_back(64'hE);
    cyc(mk(64'h8000_0180, 0, 0), 1, 1, 64'hB, 0, 0, 0);
    check("inc_dec_req", 192'(dc_req_o.data_req), 1);
    exp_q.push_back(64'hF);
    cyc(mk(64'h8000_01C0, 0, 0), 1, 0, 0, 0, 0, 0);
    check("cnt_one_req", 192'(dc_req_o.data_req), 1);
    cyc(mk(64'h8000_0200, 0, 0), 0, 0, 0, 0, 0, 0);
    check("cnt_two_mask", 192'(dc_req_o.data_req), 0);
    cyc('0, 0, 1, 64'hE, 0, 0, 0);
    cyc('0, 0, 1, 64'hF, 0, 0, 0);
    r = mk(64'h7000_0000, 1, 64'h1);
    cyc(r, 0, 0, 0, 0, 0, 0);
    check("drained_spm_issue", 192'(spm_req_o.data_req), 1);
    cyc(r, 0, 0, 0, 1, 0, 0);
    check("drained_spm_gnt", 192'(lsu_rsp_o.data_gnt), 1);

    // reset in SPM_WAIT drops the transaction and ignores the late response
    r = mk(64'h7000_0030, 0, 0);
    cyc(r, 0, 0, 0, 0, 0, 0);
    cyc(r, 0, 0, 0, 0, 0, 0);
    check("rst_wait_req", 192'(spm_req_o.data_req), 1);
    rst_v = 1'b1;
    cyc('0, 0, 0, 0, 0, 0, 0);
    check("rst_rsp", 192'(lsu_rsp_o), 0);
    rst_v = 1'b0;
    cyc('0, 0, 0, 0, 0, 1, 64'hDEAD_BEEF);
    check("rst_late_rsp", 192'(lsu_rsp_o), 0);
    check("rst_spm_req", 192'(spm_req_o.data_req), 0);
    cyc('0, 0, 0, 0, 0, 0, 0);
    check("rst_after_rsp", 192'(lsu_rsp_o), 0);

    check("scoreboard_drained", 192'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
